// File: rtl/weight_buffer_if.sv
// Handshake bundle around the weight buffer: top-level control, the global
// buffer fill stream and the weight cache read-address/read-data pair.
interface weight_buffer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int WEI_ADDR_WIDTH = 8
);
  logic                      TOPWBF_CfgVld;
  logic [WEI_ADDR_WIDTH:0]   TOPWBF_CfgLen;
  logic                      WBFTOP_CfgRdy;
  logic                      TOPWBF_Stop;
  logic                      TOPWBF_BankDone;
  logic [1:0]                WBFTOP_BankFull;
  logic                      WBFTOP_AdrErr;

  logic                      GLBWBF_DatVld;
  logic [DATA_WIDTH-1:0]     GLBWBF_Dat;
  logic                      WBFGLB_DatRdy;

  logic                      WCAWBF_AdrVld;
  logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr;
  logic                      WBFWCA_AdrRdy;
  logic                      WBFWCA_DatVld;
  logic [DATA_WIDTH-1:0]     WBFWCA_Dat;
  logic                      WCAWBF_DatRdy;

  // Master is the surrounding system (top, GLB, weight cache).
  modport master (
    output TOPWBF_CfgVld, TOPWBF_CfgLen, TOPWBF_Stop, TOPWBF_BankDone,
    output GLBWBF_DatVld, GLBWBF_Dat,
    output WCAWBF_AdrVld, WCAWBF_Adr, WCAWBF_DatRdy,
    input  WBFTOP_CfgRdy, WBFTOP_BankFull, WBFTOP_AdrErr,
    input  WBFGLB_DatRdy,
    input  WBFWCA_AdrRdy, WBFWCA_DatVld, WBFWCA_Dat
  );

  modport slave (
    input  TOPWBF_CfgVld, TOPWBF_CfgLen, TOPWBF_Stop, TOPWBF_BankDone,
    input  GLBWBF_DatVld, GLBWBF_Dat,
    input  WCAWBF_AdrVld, WCAWBF_Adr, WCAWBF_DatRdy,
    output WBFTOP_CfgRdy, WBFTOP_BankFull, WBFTOP_AdrErr,
    output WBFGLB_DatRdy,
    output WBFWCA_AdrRdy, WBFWCA_DatVld, WBFWCA_Dat
  );
endinterface

// File: rtl/weight_buffer.sv
// Ping-pong weight store: one bank fills sequentially from the global buffer
// while the weight cache reads the other by address through a small output queue.
module weight_buffer #(
  parameter int DATA_WIDTH     = 8,
  parameter int WEI_ADDR_WIDTH = 8,
  parameter int OUT_DEPTH      = 2
) (
  input logic           clk,
  input logic           rst,
  weight_buffer_if.slave bus
);

  localparam int DEPTH  = 2 ** WEI_ADDR_WIDTH;
  localparam int QIDX_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int QCNT_W = $clog2(OUT_DEPTH + 1);
  localparam logic [WEI_ADDR_WIDTH:0] LEN_ONE = (WEI_ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORK  = 2'd1,
    DRAIN = 2'd2
  } stateT;

  stateT                     state;
  logic [WEI_ADDR_WIDTH:0]   len;
  logic [1:0]                bankFull;
  logic                      wrSel;
  logic                      rdSel;
  logic [WEI_ADDR_WIDTH-1:0] wrPtr;
  logic                      adrErr;

  logic [DATA_WIDTH-1:0]     mem [2][DEPTH];

  logic [DATA_WIDTH-1:0]     outQ [OUT_DEPTH];
  logic [QIDX_W-1:0]         qHead;
  logic [QIDX_W-1:0]         qTail;
  logic [QCNT_W-1:0]         qCount;

  logic                      cfgRdy;
  logic                      cfgFire;
  logic                      fillRdy;
  logic                      fillFire;
  logic                      fillLast;
  logic                      adrRdy;
  logic                      adrFire;
  logic                      adrBad;
  logic                      popFire;
  logic                      doneTake;
  logic [DATA_WIDTH-1:0]     readWord;

  function automatic logic [QIDX_W-1:0] qNext(input logic [QIDX_W-1:0] p);
    return (p == QIDX_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cfgRdy   = (state == IDLE);
  assign cfgFire  = bus.TOPWBF_CfgVld & cfgRdy;
  assign fillRdy  = (state == WORK) & ~bankFull[wrSel];
  assign fillFire = bus.GLBWBF_DatVld & fillRdy;
  assign fillLast = fillFire & ({1'b0, wrPtr} == (len - LEN_ONE));
  // The queue already holds every outstanding read, so its occupancy is the credit count.
  assign adrRdy   = (state == WORK) & bankFull[rdSel] & (qCount < QCNT_W'(OUT_DEPTH));
  assign adrFire  = bus.WCAWBF_AdrVld & adrRdy;
  assign adrBad   = ({1'b0, bus.WCAWBF_Adr} >= len);
  assign popFire  = bus.WCAWBF_DatRdy & (qCount != '0);
  assign doneTake = bus.TOPWBF_BankDone & (state == WORK) & bankFull[rdSel];
  assign readWord = adrBad ? '0 : mem[rdSel][bus.WCAWBF_Adr];

  assign bus.WBFTOP_CfgRdy   = cfgRdy;
  assign bus.WBFTOP_BankFull = bankFull;
  assign bus.WBFTOP_AdrErr   = adrErr;
  assign bus.WBFGLB_DatRdy   = fillRdy;
  assign bus.WBFWCA_AdrRdy   = adrRdy;
  assign bus.WBFWCA_DatVld   = (qCount != '0);
  assign bus.WBFWCA_Dat      = outQ[qHead];

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (fillFire) begin
      mem[wrSel][wrPtr] <= bus.GLBWBF_Dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len      <= LEN_ONE;
      bankFull <= 2'b00;
      wrSel    <= 1'b0;
      rdSel    <= 1'b0;
      wrPtr    <= '0;
      adrErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfgFire) begin
            len    <= (bus.TOPWBF_CfgLen == '0) ? LEN_ONE : bus.TOPWBF_CfgLen;
            adrErr <= 1'b0;
            state  <= WORK;
          end
        end
        WORK: begin
          if (fillFire) begin
            wrPtr <= fillLast ? '0 : wrPtr + 1'b1;
          end
          // A filling bank is never full, so release and fill-complete never hit the same bank.
          if (fillLast) begin
            bankFull[wrSel] <= 1'b1;
            wrSel           <= ~wrSel;
          end
          if (doneTake) begin
            bankFull[rdSel] <= 1'b0;
            rdSel           <= ~rdSel;
          end
          if (adrFire && adrBad) begin
            adrErr <= 1'b1;
          end
          if (bus.TOPWBF_Stop) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (qCount == '0) begin
            bankFull <= 2'b00;
            wrSel    <= 1'b0;
            rdSel    <= 1'b0;
            wrPtr    <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data lands straight in the output queue, giving one-cycle latency when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      qHead  <= '0;
      qTail  <= '0;
      qCount <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        outQ[i] <= '0;
      end
    end else begin
      if (adrFire) begin
        outQ[qTail] <= readWord;
        qTail       <= qNext(qTail);
      end
      if (popFire) begin
        qHead <= qNext(qHead);
      end
      case ({adrFire, popFire})
        2'b10:   qCount <= qCount + QCNT_W'(1);
        2'b01:   qCount <= qCount - QCNT_W'(1);
        default: qCount <= qCount;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_buffer.sv
// Self-checking bench for weight_buffer: a vector table, directed corner-case
// sequences and a randomized phase, all checked against a queue-based model.
module tb_weight_buffer;

  localparam int DW      = 8;
  localparam int AW      = 8;
  localparam int M_IDLE  = 0;
  localparam int M_WORK  = 1;
  localparam int M_DRAIN = 2;
  localparam int NVEC    = 19;

  typedef struct {
    int cfgVld, cfgLen, glbVld, glbDat, adrVld, adr, datRdy;
    int expFull, expCfgRdy, expGlbRdy, expAdrRdy, expDatVld, expDat;
  } vecT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  weight_buffer_if #(.DATA_WIDTH(DW), .WEI_ADDR_WIDTH(AW)) bus ();

  weight_buffer #(.DATA_WIDTH(DW), .WEI_ADDR_WIDTH(AW), .OUT_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: bank contents as arrays, pending read data as a queue.
  int  mode;
  int  mLen;
  int  mWr;
  int  mRd;
  int  mPtr;
  bit  mFull [2];
  bit  mErr;
  int  mBank [2][256];
  int  outQ [$];
  bit  modelValid = 1'b0;
  int  checks = 0;
  int  errors = 0;
  vecT vec [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mode    = M_IDLE;
    mFull[0] = 1'b0;
    mFull[1] = 1'b0;
    mWr     = 0;
    mRd     = 0;
    mPtr    = 0;
    mErr    = 1'b0;
    outQ.delete();
    modelValid = 1'b1;
  endtask

  task automatic checkModel();
    if (!modelValid) return;
    checkOutput("model CfgRdy", 32'(bus.WBFTOP_CfgRdy), 32'(mode == M_IDLE));
    checkOutput("model BankFull", 32'(bus.WBFTOP_BankFull), 32'({mFull[1], mFull[0]}));
    checkOutput("model AdrErr", 32'(bus.WBFTOP_AdrErr), 32'(mErr));
    checkOutput("model GlbRdy", 32'(bus.WBFGLB_DatRdy), 32'(mode == M_WORK && !mFull[mWr]));
    checkOutput("model AdrRdy", 32'(bus.WBFWCA_AdrRdy),
                32'(mode == M_WORK && mFull[mRd] && outQ.size() < 2));
    checkOutput("model DatVld", 32'(bus.WBFWCA_DatVld), 32'(outQ.size() > 0));
    if (outQ.size() > 0) begin
      checkOutput("model Dat", 32'(bus.WBFWCA_Dat), 32'(outQ[0]));
    end
  endtask

  task automatic updateModel();
    bit popNow, pushNow, fillNow, doneNow, wasEmpty;
    int word;
    int a;
    if (rst) begin
      modelReset();
      return;
    end
    wasEmpty = (outQ.size() == 0);
    popNow   = (outQ.size() > 0) && bus.WCAWBF_DatRdy;
    pushNow  = (mode == M_WORK) && mFull[mRd] && (outQ.size() < 2) && bus.WCAWBF_AdrVld;
    fillNow  = (mode == M_WORK) && !mFull[mWr] && bus.GLBWBF_DatVld;
    doneNow  = (mode == M_WORK) && mFull[mRd] && bus.TOPWBF_BankDone;
    word = 0;
    if (pushNow) begin
      a = int'(bus.WCAWBF_Adr);
      if (a >= mLen) mErr = 1'b1;
      else word = mBank[mRd][a];
    end
    if (popNow) void'(outQ.pop_front());
    if (pushNow) outQ.push_back(word);
    if (fillNow) begin
      mBank[mWr][mPtr] = int'(bus.GLBWBF_Dat);
      if (mPtr == mLen - 1) begin
        mFull[mWr] = 1'b1;
        mWr  = 1 - mWr;
        mPtr = 0;
      end else begin
        mPtr++;
      end
    end
    if (doneNow) begin
      mFull[mRd] = 1'b0;
      mRd = 1 - mRd;
    end
    case (mode)
      M_IDLE: if (bus.TOPWBF_CfgVld) begin
        mLen = (bus.TOPWBF_CfgLen == 0) ? 1 : int'(bus.TOPWBF_CfgLen);
        mErr = 1'b0;
        mode = M_WORK;
      end
      M_WORK: if (bus.TOPWBF_Stop) mode = M_DRAIN;
      default: if (wasEmpty) begin
        mFull[0] = 1'b0;
        mFull[1] = 1'b0;
        mWr  = 0;
        mRd  = 0;
        mPtr = 0;
        mode = M_IDLE;
      end
    endcase
  endtask

  // One clock: compare against the model, take the edge, advance the model.
  task automatic applyStimulus();
    checkModel();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic drive(input int gV, input int gD, input int aV, input int a, input int dR);
    bus.TOPWBF_CfgVld   = 1'b0;
    bus.TOPWBF_CfgLen   = '0;
    bus.TOPWBF_Stop     = 1'b0;
    bus.TOPWBF_BankDone = 1'b0;
    bus.GLBWBF_DatVld   = gV[0];
    bus.GLBWBF_Dat      = gD[7:0];
    bus.WCAWBF_AdrVld   = aV[0];
    bus.WCAWBF_Adr      = a[7:0];
    bus.WCAWBF_DatRdy   = dR[0];
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    vec[0]  = '{1, 4, 0, 0,     0, 0, 0,  0, 1, 0, 0, 0, 0};
    vec[1]  = '{0, 0, 1, 'h11,  0, 0, 0,  0, 0, 1, 0, 0, 0};
    vec[2]  = '{0, 0, 1, 'h22,  0, 0, 0,  0, 0, 1, 0, 0, 0};
    vec[3]  = '{0, 0, 1, 'h33,  0, 0, 0,  0, 0, 1, 0, 0, 0};
    vec[4]  = '{0, 0, 1, 'h44,  0, 0, 0,  0, 0, 1, 0, 0, 0};
    vec[5]  = '{0, 0, 0, 0,     1, 2, 0,  1, 0, 1, 1, 0, 0};
    vec[6]  = '{0, 0, 0, 0,     1, 0, 1,  1, 0, 1, 1, 1, 'h33};
    vec[7]  = '{0, 0, 0, 0,     1, 1, 1,  1, 0, 1, 1, 1, 'h11};
    vec[8]  = '{0, 0, 0, 0,     1, 2, 1,  1, 0, 1, 1, 1, 'h22};
    vec[9]  = '{0, 0, 0, 0,     1, 3, 1,  1, 0, 1, 1, 1, 'h33};
    vec[10] = '{0, 0, 0, 0,     0, 0, 1,  1, 0, 1, 1, 1, 'h44};
    vec[11] = '{0, 0, 0, 0,     1, 0, 0,  1, 0, 1, 1, 0, 0};
    vec[12] = '{0, 0, 0, 0,     1, 1, 0,  1, 0, 1, 1, 1, 'h11};
    vec[13] = '{0, 0, 0, 0,     1, 2, 0,  1, 0, 1, 0, 1, 'h11};
    vec[14] = '{0, 0, 0, 0,     1, 2, 1,  1, 0, 1, 0, 1, 'h11};
    vec[15] = '{0, 0, 0, 0,     1, 2, 1,  1, 0, 1, 1, 1, 'h22};
    vec[16] = '{0, 0, 0, 0,     1, 3, 1,  1, 0, 1, 1, 1, 'h33};
    vec[17] = '{0, 0, 0, 0,     0, 0, 1,  1, 0, 1, 1, 1, 'h44};
    vec[18] = '{0, 0, 0, 0,     0, 0, 0,  1, 0, 1, 1, 0, 0};

    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    modelReset();
    #1;
    rst = 1'b0;
    $display("[TB] reset released");
    checkOutput("reset CfgRdy", 32'(bus.WBFTOP_CfgRdy), 32'd1);
    checkOutput("reset BankFull", 32'(bus.WBFTOP_BankFull), 32'd0);
    checkOutput("reset DatVld", 32'(bus.WBFWCA_DatVld), 32'd0);
    checkOutput("reset Dat", 32'(bus.WBFWCA_Dat), 32'd0);
    checkOutput("reset AdrRdy", 32'(bus.WBFWCA_AdrRdy), 32'd0);
    checkOutput("reset GlbRdy", 32'(bus.WBFGLB_DatRdy), 32'd0);
    checkOutput("reset AdrErr", 32'(bus.WBFTOP_AdrErr), 32'd0);

    // Vector table: config, fill bank0, single read, burst, stalled burst.
    for (int i = 0; i < NVEC; i++) begin
      drive(vec[i].glbVld, vec[i].glbDat, vec[i].adrVld, vec[i].adr, vec[i].datRdy);
      bus.TOPWBF_CfgVld = vec[i].cfgVld[0];
      bus.TOPWBF_CfgLen = vec[i].cfgLen[8:0];
      checkOutput($sformatf("vec%0d BankFull", i), 32'(bus.WBFTOP_BankFull), 32'(vec[i].expFull));
      checkOutput($sformatf("vec%0d CfgRdy", i), 32'(bus.WBFTOP_CfgRdy), 32'(vec[i].expCfgRdy));
      checkOutput($sformatf("vec%0d GlbRdy", i), 32'(bus.WBFGLB_DatRdy), 32'(vec[i].expGlbRdy));
      checkOutput($sformatf("vec%0d AdrRdy", i), 32'(bus.WBFWCA_AdrRdy), 32'(vec[i].expAdrRdy));
      checkOutput($sformatf("vec%0d DatVld", i), 32'(bus.WBFWCA_DatVld), 32'(vec[i].expDatVld));
      if (vec[i].expDatVld != 0) begin
        checkOutput($sformatf("vec%0d Dat", i), 32'(bus.WBFWCA_Dat), 32'(vec[i].expDat));
      end
      applyStimulus();
    end

    // Fill bank1 while reading bank0, then release bank0.
    for (int i = 0; i < 4; i++) begin
      drive(1, 'hA0 + i, 1, i, 1);
      applyStimulus();
    end
    drive(0, 0, 0, 0, 1);
    applyStimulus();
    checkOutput("both full BankFull", 32'(bus.WBFTOP_BankFull), 32'd3);
    checkOutput("both full GlbRdy", 32'(bus.WBFGLB_DatRdy), 32'd0);
    drive(1, 'hFF, 0, 0, 1);
    applyStimulus();
    drive(0, 0, 0, 0, 1);
    bus.TOPWBF_BankDone = 1'b1;
    applyStimulus();
    drive(0, 0, 0, 0, 0);
    checkOutput("release BankFull", 32'(bus.WBFTOP_BankFull), 32'd2);
    checkOutput("release GlbRdy", 32'(bus.WBFGLB_DatRdy), 32'd1);
    drive(0, 0, 1, 0, 0);
    applyStimulus();
    drive(0, 0, 0, 0, 0);
    checkOutput("bank1 read DatVld", 32'(bus.WBFWCA_DatVld), 32'd1);
    checkOutput("bank1 read Dat", 32'(bus.WBFWCA_Dat), 32'hA0);
    drive(0, 0, 0, 0, 1);
    applyStimulus();

    // Out-of-range read and ignored BankDone.
    drive(0, 0, 1, 5, 0);
    applyStimulus();
    drive(0, 0, 0, 0, 0);
    checkOutput("bad adr Dat", 32'(bus.WBFWCA_Dat), 32'd0);
    checkOutput("bad adr AdrErr", 32'(bus.WBFTOP_AdrErr), 32'd1);
    drive(0, 0, 0, 0, 1);
    applyStimulus();
    applyStimulus();
    checkOutput("sticky AdrErr", 32'(bus.WBFTOP_AdrErr), 32'd1);
    bus.TOPWBF_BankDone = 1'b1;
    applyStimulus();
    bus.TOPWBF_BankDone = 1'b1;
    applyStimulus();
    drive(0, 0, 0, 0, 0);
    checkOutput("ignored done BankFull", 32'(bus.WBFTOP_BankFull), 32'd0);

    // Last fill word to bank1 in the same cycle bank0 is released.
    for (int i = 0; i < 8; i++) begin
      drive(1, (i < 4) ? ('h50 + i) : ('h5C + i), 0, 0, 0);
      bus.TOPWBF_BankDone = (i == 7);
      applyStimulus();
    end
    drive(0, 0, 0, 0, 0);
    checkOutput("simul BankFull", 32'(bus.WBFTOP_BankFull), 32'd2);
    checkOutput("simul GlbRdy", 32'(bus.WBFGLB_DatRdy), 32'd1);

    // Stop with two reads outstanding and the consumer stalled.
    drive(0, 0, 1, 0, 0);
    applyStimulus();
    drive(0, 0, 1, 1, 0);
    applyStimulus();
    drive(0, 0, 0, 0, 0);
    checkOutput("simul read Dat", 32'(bus.WBFWCA_Dat), 32'h60);
    bus.TOPWBF_Stop = 1'b1;
    applyStimulus();
    drive(0, 0, 0, 0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("drain held CfgRdy", 32'(bus.WBFTOP_CfgRdy), 32'd0);
    checkOutput("drain held DatVld", 32'(bus.WBFWCA_DatVld), 32'd1);
    drive(0, 0, 0, 0, 1);
    n = 0;
    while (bus.WBFTOP_CfgRdy !== 1'b1 && n < 8) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain to idle CfgRdy", 32'(bus.WBFTOP_CfgRdy), 32'd1);
    checkOutput("drain to idle BankFull", 32'(bus.WBFTOP_BankFull), 32'd0);

    // Reset in the middle of a burst with reads pending.
    drive(0, 0, 0, 0, 0);
    bus.TOPWBF_CfgVld = 1'b1;
    bus.TOPWBF_CfgLen = 9'd2;
    applyStimulus();
    drive(1, 'h70, 0, 0, 0);
    applyStimulus();
    drive(1, 'h71, 0, 0, 0);
    applyStimulus();
    drive(0, 0, 1, 0, 0);
    applyStimulus();
    drive(0, 0, 1, 3, 0);
    applyStimulus();
    drive(0, 0, 1, 1, 0);
    checkOutput("pre-reset AdrErr", 32'(bus.WBFTOP_AdrErr), 32'd1);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    checkOutput("mid reset DatVld", 32'(bus.WBFWCA_DatVld), 32'd0);
    checkOutput("mid reset BankFull", 32'(bus.WBFTOP_BankFull), 32'd0);
    checkOutput("mid reset AdrErr", 32'(bus.WBFTOP_AdrErr), 32'd0);
    checkOutput("mid reset CfgRdy", 32'(bus.WBFTOP_CfgRdy), 32'd1);

    // Randomized layers, including a zero-length config.
    for (int layer = 0; layer < 4; layer++) begin
      drive(0, 0, 0, 0, 0);
      bus.TOPWBF_CfgVld = 1'b1;
      bus.TOPWBF_CfgLen = (layer == 0) ? 9'd0 : 9'($urandom_range(1, 6));
      applyStimulus();
      for (int c = 0; c < 250; c++) begin
        drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, mLen + 1)),
              int'($urandom_range(0, 3) != 0));
        bus.TOPWBF_BankDone = ($urandom_range(0, 11) == 0);
        applyStimulus();
      end
      drive(0, 0, 0, 0, 0);
      bus.TOPWBF_Stop = 1'b1;
      applyStimulus();
      drive(0, 0, 0, 0, 1);
      n = 0;
      while (mode != M_IDLE && n < 20) begin
        applyStimulus();
        n++;
      end
      checkOutput($sformatf("layer%0d idle CfgRdy", layer), 32'(bus.WBFTOP_CfgRdy), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_buffer.md
Name: weight_buffer

Overview:
Double-banked (ping-pong) on-chip weight store that sits directly upstream of the weight cache. One bank is filled sequentially from the global buffer while the weight cache reads the other bank by address. It answers the cache's read-address/read-data handshakes with 1-cycle latency and up to 2 outstanding reads. Bank ownership is swapped by a fill-complete event on the write side and a release pulse from top control on the read side.

Parameters:
DATA_WIDTH, 8, weight word width
WEI_ADDR_WIDTH, 8, per-bank address width; bank depth = 2**WEI_ADDR_WIDTH
OUT_DEPTH, 2, output queue depth = maximum outstanding reads

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
TOPWBF_CfgVld  in  1  config valid
TOPWBF_CfgLen  in  WEI_ADDR_WIDTH+1  words per bank fill, legal range 1..2**WEI_ADDR_WIDTH
WBFTOP_CfgRdy  out  1  config ready; high only in IDLE
TOPWBF_Stop  in  1  pulse; end of layer
TOPWBF_BankDone  in  1  pulse; weight cache has finished with the current read bank
WBFTOP_BankFull  out  2  per-bank full flags
WBFTOP_AdrErr  out  1  sticky out-of-range read flag
GLBWBF_DatVld  in  1  fill data valid
GLBWBF_Dat  in  DATA_WIDTH  fill data
WBFGLB_DatRdy  out  1  fill data ready
WCAWBF_AdrVld  in  1  read address valid
WCAWBF_Adr  in  WEI_ADDR_WIDTH  read address
WBFWCA_AdrRdy  out  1  read address ready
WBFWCA_DatVld  out  1  read data valid
WBFWCA_Dat  out  DATA_WIDTH  read data
WCAWBF_DatRdy  in  1  read data ready

Behaviour:
- Reset: state=IDLE; WBFTOP_BankFull=0; wr_sel=0; rd_sel=0; wr_ptr=0; output queue empty; WBFWCA_DatVld=0; WBFWCA_Dat=0; WBFWCA_AdrRdy=0; WBFGLB_DatRdy=0; WBFTOP_AdrErr=0; WBFTOP_CfgRdy=1 in the cycle after rst deasserts. Memory contents are not reset.
- Reset asserted in any state, including with reads in flight, returns the block to the reset values above on the next edge. In-flight data is discarded.
- All handshakes transfer on Vld&Rdy at the rising edge.
- FSM, IDLE→WORK: on CfgVld&CfgRdy. Latch len; CfgLen=0 is clamped to 1.
- FSM, WORK→DRAIN: on TOPWBF_Stop.
- FSM, DRAIN→IDLE: once the output queue is empty and no read is in flight. Entering IDLE clears BankFull, wr_ptr, wr_sel, rd_sel. AdrErr is kept; it clears only on rst or on a new config.
- Fill side:
  - WBFGLB_DatRdy = (state==WORK) & !BankFull[wr_sel].
  - Each accepted word writes mem[wr_sel][wr_ptr] and increments wr_ptr.
  - When the word at wr_ptr==len-1 is accepted: BankFull[wr_sel] set, wr_sel toggles, wr_ptr=0.
  - Both banks full → DatRdy low; no overwrite.
- Read side:
  - WBFWCA_AdrRdy = (state==WORK) & BankFull[rd_sel] & (queue occupancy + in-flight < OUT_DEPTH).
  - Memory is synchronous-read. An address accepted in cycle t gives WBFWCA_DatVld=1 with its data in cycle t+1 if the queue was empty.
  - With DatRdy held high, sustained throughput is 1 word/cycle. Data order equals address order.
  - Under backpressure, data is held stable until accepted; no loss, no duplication.
  - Adr ≥ len: returned data is 0 and AdrErr is set; the transaction otherwise completes normally.
- TOPWBF_BankDone:
  - In WORK with BankFull[rd_sel]=1: clears BankFull[rd_sel] and toggles rd_sel.
  - Ignored if BankFull[rd_sel]=0 or not in WORK.
  - Data already in flight for the released bank is still delivered, since it was read before the release.
- Simultaneous events: a fill completing on wr_sel and BankDone on rd_sel in the same cycle both take effect. If wr_sel==rd_sel, that bank was empty, so BankDone is ignored and the fill completes. An address accept in the same cycle as BankDone uses the old rd_sel.
- Stop during a partial fill: the partial bank stays not-full and is discarded on the return to IDLE.

Test Plan:
1. Cfg len=4; fill 0x11,0x22,0x33,0x44 → BankFull=01, wr_sel=1; read adr 2 in cycle t → DatVld at t+1, Dat=0x33.
2. Bank0 full; burst reads adr 0..3 with DatRdy=1 → one word/cycle, 0x11,0x22,0x33,0x44 in order. Repeat with DatRdy low for 3 cycles mid-burst → AdrRdy drops after 2 outstanding; no loss; Dat stable while stalled.
3. Fill bank1 (0xA0..0xA3) while reading bank0 → both flags set; GLB DatRdy=0 with both full. BankDone → rd_sel=1, BankFull=10; read adr 0 returns 0xA0; GLB DatRdy returns to 1.
4. Read adr 5 with len=4 → Dat=0x00, AdrErr=1 and sticky; BankDone while BankFull[rd_sel]=0 → no flag change.
5. Same cycle: last fill word to bank1 and BankDone on bank0 → BankFull 01→10, rd_sel=1, wr_sel=0.
6. Stop with 2 reads outstanding and DatRdy=0 → stays in DRAIN; after both words are accepted → IDLE, CfgRdy=1, BankFull=00. rst mid-burst → next cycle DatVld=0 and all flags 0.
